// File: rtl/fpu_mul_param.sv
// Parametrised 4-stage IEEE-754 multiplier: four rounding modes, exception flags,
// valid/ready handshake with backpressure. Subnormal inputs flush to zero.
module fpu_mul_param #(
    parameter  int EXP_W  = 11,
    parameter  int FRAC_W = 52,
    localparam int W      = 1 + EXP_W + FRAC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    input  logic [1:0]   rmode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] outfp,
    output logic [3:0]   flags
);
    localparam int M      = FRAC_W + 1;
    localparam int XW     = EXP_W + 2;
    localparam int STAGES = 4;
    localparam logic [EXP_W-1:0]  EONES = '1;
    localparam logic [FRAC_W-1:0] FONES = '1;
    localparam logic [XW-1:0]     BIAS  = XW'((64'd1 << (EXP_W - 1)) - 64'd1);
    localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11;

    typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_t;

    typedef struct packed {
        logic             sign;
        logic [1:0]       rm;
        kind_t            kind;
        logic             invalid;
        logic [EXP_W-1:0] ea;
        logic [EXP_W-1:0] eb;
        logic [M-1:0]     ma;
        logic [M-1:0]     mb;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic [1:0]       rm;
        kind_t            kind;
        logic             invalid;
        logic [XW-1:0]    exp;
        logic [2*M-1:0]   prod;
    } s2_t;

    typedef struct packed {
        logic              sign;
        logic [1:0]        rm;
        kind_t             kind;
        logic              invalid;
        logic [XW-1:0]     exp;
        logic [FRAC_W-1:0] frac;
        logic              inexact;
    } s3_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;

    // Whole pipeline moves in lockstep; bubbles travel as valid=0.
    logic [STAGES:1] vld_q;
    logic [STAGES:0] vld_pipe;
    logic            advance;

    assign out_valid = vld_pipe[STAGES];
    assign advance   = !vld_q[STAGES] || out_ready;
    assign in_ready  = advance;
    assign vld_pipe  = {vld_q, in_valid && advance};

    // S1: unpack and classify
    logic [EXP_W-1:0]  ea, eb;
    logic [FRAC_W-1:0] fa, fb;
    logic za, zb, ia, ib, na, nb, sna, snb, inf_zero;

    assign ea  = opa[W-2:FRAC_W];
    assign eb  = opb[W-2:FRAC_W];
    assign fa  = opa[FRAC_W-1:0];
    assign fb  = opb[FRAC_W-1:0];
    assign za  = (ea == '0);
    assign zb  = (eb == '0);
    assign ia  = (ea == EONES) && (fa == '0);
    assign ib  = (eb == EONES) && (fb == '0);
    assign na  = (ea == EONES) && (fa != '0);
    assign nb  = (eb == EONES) && (fb != '0);
    assign sna = na && !fa[FRAC_W-1];
    assign snb = nb && !fb[FRAC_W-1];
    assign inf_zero = (ia && zb) || (ib && za);

    always_comb begin
        s1_d         = '0;
        s1_d.sign    = opa[W-1] ^ opb[W-1];
        s1_d.rm      = rmode;
        s1_d.invalid = sna || snb || inf_zero;
        s1_d.ea      = ea;
        s1_d.eb      = eb;
        s1_d.ma      = {1'b1, fa};
        s1_d.mb      = {1'b1, fb};
        if (na || nb || inf_zero) s1_d.kind = K_NAN;
        else if (ia || ib)        s1_d.kind = K_INF;
        else if (za || zb)        s1_d.kind = K_ZERO;
        else                      s1_d.kind = K_NUM;
    end

    // S2: mantissa product and signed exponent sum
    always_comb begin
        s2_d         = '0;
        s2_d.sign    = s1_q.sign;
        s2_d.rm      = s1_q.rm;
        s2_d.kind    = s1_q.kind;
        s2_d.invalid = s1_q.invalid;
        s2_d.prod    = {{M{1'b0}}, s1_q.ma} * {{M{1'b0}}, s1_q.mb};
        s2_d.exp     = {2'b00, s1_q.ea} + {2'b00, s1_q.eb} - BIAS;
    end

    // S3: normalise, then round on guard/round/sticky
    logic         top, g, r, st, lost, inc;
    logic [M-1:0] mant;
    logic [M:0]   mr;

    always_comb begin
        top  = s2_q.prod[2*M-1];
        mant = top ? s2_q.prod[2*M-1:M] : s2_q.prod[2*M-2:M-1];
        g    = top ? s2_q.prod[M-1] : s2_q.prod[M-2];
        r    = top ? s2_q.prod[M-2] : s2_q.prod[M-3];
        st   = top ? |s2_q.prod[M-3:0] : |s2_q.prod[M-4:0];
        lost = g | r | st;
        case (s2_q.rm)
            RNE:     inc = g & (r | st | mant[0]);
            RUP:     inc = !s2_q.sign & lost;
            RDN:     inc = s2_q.sign & lost;
            default: inc = 1'b0;
        endcase
        mr           = {1'b0, mant} + {{M{1'b0}}, inc};
        s3_d         = '0;
        s3_d.sign    = s2_q.sign;
        s3_d.rm      = s2_q.rm;
        s3_d.kind    = s2_q.kind;
        s3_d.invalid = s2_q.invalid;
        s3_d.exp     = s2_q.exp + {{(XW-1){1'b0}}, top} + {{(XW-1){1'b0}}, mr[M]};
        s3_d.frac    = mr[M] ? mr[M-1:1] : mr[M-2:0];
        s3_d.inexact = lost;
    end

    // S4: range check and pack; exp is two's complement in XW bits
    logic         ovf, unf, to_inf;
    logic [W-1:0] res_d;
    logic [3:0]   flg_d;

    always_comb begin
        ovf = !s3_q.exp[XW-1] && (s3_q.exp[XW-2:0] >= {1'b0, EONES});
        unf = s3_q.exp[XW-1] || (s3_q.exp == '0);
        case (s3_q.rm)
            RNE:     to_inf = 1'b1;
            RTZ:     to_inf = 1'b0;
            RUP:     to_inf = !s3_q.sign;
            default: to_inf = s3_q.sign;
        endcase
        res_d = {s3_q.sign, s3_q.exp[EXP_W-1:0], s3_q.frac};
        flg_d = {3'b000, s3_q.inexact};
        case (s3_q.kind)
            K_NAN: begin
                res_d = {1'b0, EONES, 1'b1, {(FRAC_W-1){1'b0}}};
                flg_d = {s3_q.invalid, 3'b000};
            end
            K_INF: begin
                res_d = {s3_q.sign, EONES, {FRAC_W{1'b0}}};
                flg_d = 4'b0000;
            end
            K_ZERO: begin
                res_d = {s3_q.sign, {(W-1){1'b0}}};
                flg_d = 4'b0000;
            end
            default: begin
                if (ovf) begin
                    res_d = to_inf ? {s3_q.sign, EONES, {FRAC_W{1'b0}}}
                                   : {s3_q.sign, EONES[EXP_W-1:1], 1'b0, FONES};
                    flg_d = 4'b0101;
                end else if (unf) begin
                    res_d = {s3_q.sign, {(W-1){1'b0}}};
                    flg_d = 4'b0011;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            outfp <= '0;
            flags <= '0;
        end else if (advance) begin
            vld_q <= vld_pipe[STAGES-1:0];
            if (vld_pipe[STAGES-1]) begin
                outfp <= res_d;
                flags <= flg_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end
endmodule

// File: tb/tb_fpu_mul_param.sv
// Scoreboard bench for fpu_mul_param: double and single precision instances,
// directed corner cases plus randomized traffic against an integer reference model.
module tb_fpu_mul_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] opa, opb, outfp;
    logic [1:0]  rmode;
    logic [3:0]  flags;

    logic        sp_in_valid, sp_in_ready, sp_out_valid, sp_out_ready;
    logic [31:0] sp_opa, sp_opb, sp_outfp;
    logic [1:0]  sp_rmode;
    logic [3:0]  sp_flags;

    fpu_mul_param #(.EXP_W(11), .FRAC_W(52)) u_dp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opa(opa), .opb(opb), .rmode(rmode), .out_valid(out_valid),
        .out_ready(out_ready), .outfp(outfp), .flags(flags));

    fpu_mul_param #(.EXP_W(8), .FRAC_W(23)) u_sp (
        .clk(clk), .rst(rst), .in_valid(sp_in_valid), .in_ready(sp_in_ready),
        .opa(sp_opa), .opb(sp_opb), .rmode(sp_rmode), .out_valid(sp_out_valid),
        .out_ready(sp_out_ready), .outfp(sp_outfp), .flags(sp_flags));

    typedef struct {
        logic [63:0] res;
        logic [3:0]  fl;
        int          id;
    } exp_t;

    exp_t dq[$];
    exp_t sq[$];
    int   checks = 0;
    int   errors = 0;
    int   dp_n = 0;
    int   sp_n = 0;
    bit   saw_drop = 0;
    bit   rnd_done = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: exact integer product, remainder-based rounding.
    function automatic void ref_mul(input int ew, input int fw, input logic [63:0] a,
                                    input logic [63:0] b, input logic [1:0] rm,
                                    output logic [63:0] res, output logic [3:0] fl);
        longint       emax, bias, ea, eb, e;
        logic [63:0]  fmask, fa, fb, sgn;
        logic [127:0] p, m, rem, half;
        bit           s, za, zb, ia, ib, na, nb, sa, sb, inx, up, toinf;
        int           sh;
        emax  = (longint'(1) << ew) - 1;
        bias  = emax >> 1;
        fmask = (64'd1 << fw) - 64'd1;
        ea    = longint'(a >> fw) & emax;
        eb    = longint'(b >> fw) & emax;
        fa    = a & fmask;
        fb    = b & fmask;
        s     = a[ew+fw] ^ b[ew+fw];
        sgn   = 64'(s) << (ew + fw);
        za    = (ea == 0);
        zb    = (eb == 0);
        ia    = (ea == emax) && (fa == 0);
        ib    = (eb == emax) && (fb == 0);
        na    = (ea == emax) && (fa != 0);
        nb    = (eb == emax) && (fb != 0);
        sa    = na && (fa[fw-1] == 1'b0);
        sb    = nb && (fb[fw-1] == 1'b0);
        fl    = 4'b0000;
        if (na || nb || (ia && zb) || (ib && za)) begin
            res   = (64'(emax) << fw) | (64'd1 << (fw - 1));
            fl[3] = sa || sb || (ia && zb) || (ib && za);
            return;
        end
        if (ia || ib) begin
            res = sgn | (64'(emax) << fw);
            return;
        end
        if (za || zb) begin
            res = sgn;
            return;
        end
        p  = 128'(fa | (64'd1 << fw)) * 128'(fb | (64'd1 << fw));
        e  = ea + eb - bias;
        sh = fw;
        if ((p >> (2 * fw + 1)) != 0) begin
            sh = fw + 1;
            e  = e + 1;
        end
        m    = p >> sh;
        rem  = p - (m << sh);
        half = 128'd1 << (sh - 1);
        inx  = (rem != 0);
        case (rm)
            2'b00:   up = (rem > half) || ((rem == half) && m[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = !s && inx;
            default: up = s && inx;
        endcase
        if (up) m = m + 1;
        if ((m >> (fw + 1)) != 0) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= emax) begin
            toinf = (rm == 2'b00) || (rm == 2'b10 && !s) || (rm == 2'b11 && s);
            res   = toinf ? (sgn | (64'(emax) << fw)) : (sgn | (64'(emax - 1) << fw) | fmask);
            fl    = 4'b0101;
        end else if (e <= 0) begin
            res = sgn;
            fl  = 4'b0011;
        end else begin
            res = sgn | (64'(e) << fw) | (64'(m) & fmask);
            fl  = {3'b000, inx};
        end
    endfunction

    function automatic logic [63:0] gen_op(input int ew, input int fw);
        logic [63:0] emax, bias, e, f, s, qb;
        int span;
        emax = (64'd1 << ew) - 64'd1;
        bias = emax >> 1;
        qb   = 64'd1 << (fw - 1);
        f    = {$urandom, $urandom} & ((64'd1 << fw) - 64'd1);
        s    = 64'($urandom_range(0, 1));
        span = int'(bias) / 2;
        case ($urandom_range(0, 19))
            0:       begin e = 64'd0; f = 64'd0; end
            1:       e = 64'd0;
            2:       begin e = emax; f = 64'd0; end
            3:       begin e = emax; f = f | qb; end
            4:       begin e = emax; f = (f & ~qb) | 64'd1; end
            5, 6:    e = 64'($urandom_range(1, int'(emax) - 1));
            7:       e = emax - 64'd1 - 64'($urandom_range(0, 3));
            8, 9:    begin
                         e = bias + 64'($urandom_range(0, 2 * span)) - 64'(span);
                         f = f & ~((64'd1 << (fw - 4)) - 64'd1);
                     end
            default: e = bias + 64'($urandom_range(0, 2 * span)) - 64'(span);
        endcase
        return (s << (ew + fw)) | (e << fw) | f;
    endfunction

    task automatic dp_issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] rm,
                            input logic [63:0] er, input logic [3:0] ef);
        exp_t e;
        int   n;
        opa = a; opb = b; rmode = rm; in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.res = er; e.fl = ef; e.id = dp_n++;
                dq.push_back(e);
                @(posedge clk); #1;
                break;
            end
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL dp_accept_timeout: in_ready stayed 0, expected 1");
                in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic sp_issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                            input logic [31:0] er, input logic [3:0] ef);
        exp_t e;
        int   n;
        sp_opa = a; sp_opb = b; sp_rmode = rm; sp_in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (sp_in_ready) begin
                e.res = {32'd0, er}; e.fl = ef; e.id = sp_n++;
                sq.push_back(e);
                @(posedge clk); #1;
                break;
            end
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL sp_accept_timeout: in_ready stayed 0, expected 1");
                sp_in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic dp_rand(input bit gap);
        logic [63:0] a, b, r;
        logic [3:0]  f;
        logic [1:0]  rm;
        a  = gen_op(11, 52);
        b  = gen_op(11, 52);
        rm = 2'($urandom_range(0, 3));
        ref_mul(11, 52, a, b, rm, r, f);
        if (gap && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        dp_issue(a, b, rm, r, f);
    endtask

    task automatic sp_rand();
        logic [63:0] a, b, r;
        logic [3:0]  f;
        logic [1:0]  rm;
        a  = gen_op(8, 23);
        b  = gen_op(8, 23);
        rm = 2'($urandom_range(0, 3));
        ref_mul(8, 23, a, b, rm, r, f);
        sp_issue(a[31:0], b[31:0], rm, r[31:0], f);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((dq.size() != 0 || sq.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 128'(dq.size() + sq.size()), 128'(0));
    endtask

    // Double-precision monitor: pops on handshake, checks hold while stalled.
    initial begin
        bit          stl;
        logic [67:0] hv;
        exp_t        e;
        stl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stl = 1'b0;
            end else begin
                if (!in_ready) saw_drop = 1'b1;
                if (stl) check("dp_hold", 128'({out_valid, outfp, flags}), 128'({1'b1, hv}));
                if (out_valid && out_ready) begin
                    if (dq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL dp_extra: got %0h, expected no output", outfp);
                    end else begin
                        e = dq.pop_front();
                        check($sformatf("dp_op%0d", e.id), 128'({outfp, flags}), 128'({e.res, e.fl}));
                    end
                    stl = 1'b0;
                end else if (out_valid) begin
                    stl = 1'b1;
                    hv  = {outfp, flags};
                end else begin
                    stl = 1'b0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && sp_out_valid && sp_out_ready) begin
                if (sq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sp_extra: got %0h, expected no output", sp_outfp);
                end else begin
                    e = sq.pop_front();
                    check($sformatf("sp_op%0d", e.id), 128'({sp_outfp, sp_flags}),
                          128'({e.res[31:0], e.fl}));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit vseen;
        rst = 1'b1;
        in_valid = 1'b0; opa = '0; opb = '0; rmode = '0; out_ready = 1'b1;
        sp_in_valid = 1'b0; sp_opa = '0; sp_opb = '0; sp_rmode = '0; sp_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("dp_reset_state", 128'({in_ready, out_valid, outfp, flags}), 128'({1'b1, 1'b0, 64'd0, 4'd0}));
        check("sp_reset_state", 128'({sp_in_ready, sp_out_valid, sp_outfp, sp_flags}),
              128'({1'b1, 1'b0, 32'd0, 4'd0}));

        // first result latency
        dp_issue(64'h404C59999999999A, 64'h4007EB851EB851EC, 2'b00, 64'h4065310E56041894, 4'b0001);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("dp_latency", 128'(lat), 128'(4));

        // directed corners, streamed back to back
        dp_issue(64'h40F5F8F000000000, 64'h4030000000000000, 2'b00, 64'h4135F8F000000000, 4'b0000);
        dp_issue(64'h7FF0000000000000, 64'h1661234567890ABC, 2'b00, 64'h7FF0000000000000, 4'b0000);
        dp_issue(64'h00000000005CA703, 64'h4DF2A5C3A1000000, 2'b00, 64'h0000000000000000, 4'b0000);
        dp_issue(64'h7FF0000000000000, 64'h0000000000000000, 2'b00, 64'h7FF8000000000000, 4'b1000);
        dp_issue(64'h0C32F5E2D5A8E4B1, 64'h2B4D4B1E0AAAC1C0, 2'b00, 64'h0000000000000000, 4'b0011);
        dp_issue(64'h7FE0000000000000, 64'h4000000000000000, 2'b00, 64'h7FF0000000000000, 4'b0101);
        dp_issue(64'h7FE0000000000000, 64'h4000000000000000, 2'b01, 64'h7FEFFFFFFFFFFFFF, 4'b0101);
        dp_issue(64'hFFE0000000000000, 64'h4000000000000000, 2'b10, 64'hFFEFFFFFFFFFFFFF, 4'b0101);
        dp_issue(64'hFFE0000000000000, 64'h4000000000000000, 2'b11, 64'hFFF0000000000000, 4'b0101);
        dp_issue(64'h7FF8000000000000, 64'h3FF0000000000000, 2'b00, 64'h7FF8000000000000, 4'b0000);
        dp_issue(64'h7FF0000000000001, 64'h3FF0000000000000, 2'b00, 64'h7FF8000000000000, 4'b1000);
        dp_issue(64'h8000000000000000, 64'h4014000000000000, 2'b00, 64'h8000000000000000, 4'b0000);
        in_valid = 1'b0;
        drain("dp_directed_drain");

        // backpressure mid-stream
        saw_drop = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) dp_rand(1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("dp_backpressure_drain");
        check("dp_in_ready_drop", 128'(saw_drop), 128'(1));

        // reset with three operations in flight
        for (int i = 0; i < 3; i++) dp_rand(1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        dq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        check("dp_rst_flush", 128'({out_valid, outfp, flags}), 128'(0));
        vseen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            vseen = vseen | out_valid;
        end
        check("dp_rst_no_stale", 128'(vseen), 128'(0));

        // randomized traffic with random consumer stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) dp_rand(1'b1);
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 9) < 7);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain("dp_random_drain");

        // single precision
        sp_issue(32'h40400000, 32'h40000000, 2'b00, 32'h40C00000, 4'b0000);
        sp_issue(32'h3EAAAAAB, 32'h40400000, 2'b00, 32'h3F800000, 4'b0001);
        for (int i = 0; i < 100; i++) sp_rand();
        sp_in_valid = 1'b0;
        drain("sp_random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
